comparator_bist: RTL

- Synthesizable stimulus-and-check engine for the magnitude comparator: it drives the comparator's a/b inputs and checks its gt/eq/lt outputs.
- On a start pulse it sweeps every {a,b} combination, holds each for a settle window, and samples the comparator result at the end of the window.
- It counts mismatches, records the first failing vector, and reports pass/fail.
- It sits beside the comparator in the day-level top as an on-chip self-test, replacing the manual stimulus sequence.

---
 rtl/comparator_bist_if.sv | 30 +++
 rtl/comparator_bist.sv | 120 ++++++++++++
 2 files changed

// File: rtl/comparator_bist_if.sv
// Signal bundle between the comparator self-test engine and its environment.
// The master side is the BIST engine: it drives the operands and the status,
// and receives start plus the comparator's gt/eq/lt results.
interface comparator_bist_if #(
  parameter int WIDTH = 1,
  parameter int ERR_W = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic                 gt_in;
  logic                 eq_in;
  logic                 lt_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_count;
  logic [2*WIDTH-1:0]   first_fail;
  logic                 fail_valid;

  modport master (
    input  start, gt_in, eq_in, lt_in,
    output a_out, b_out, busy, done, pass, err_count, first_fail, fail_valid
  );

  modport slave (
    output start, gt_in, eq_in, lt_in,
    input  a_out, b_out, busy, done, pass, err_count, first_fail, fail_valid
  );
endinterface

// File: rtl/comparator_bist.sv
// Exhaustive self-test for a magnitude comparator. A start pulse sweeps every
// {a,b} pair, holds each for HOLD_CYCLES, samples gt/eq/lt on the last cycle
// of the hold window, counts mismatches and remembers the first bad vector.
module comparator_bist #(
  parameter int WIDTH       = 1,
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  comparator_bist_if.master bus
);
  localparam int VEC_W = 2 * WIDTH;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t             state, state_next;
  logic [VEC_W-1:0]   vec;
  logic [CNT_W-1:0]   hold_cnt;
  logic [ERR_W-1:0]   err_count;
  logic [VEC_W-1:0]   first_fail;
  logic               fail_valid;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_val;
  logic [WIDTH-1:0]   b_val;
  logic               accept;
  logic               sample;
  logic               last_vec;
  logic               mismatch;
  logic [2:0]         expected;
  logic [2:0]         observed;

  assign a_val = vec[VEC_W-1:WIDTH];
  assign b_val = vec[WIDTH-1:0];

  // Decode the sweep position and compare the comparator against a golden model.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    accept   = 1'b0;
    sample   = 1'b0;
    last_vec = 1'b0;
    mismatch = 1'b0;
    expected = {a_val > b_val, a_val == b_val, a_val < b_val};
    observed = {bus.gt_in, bus.eq_in, bus.lt_in};
    accept   = bus.start && (state != DRIVE);
    sample   = (state == DRIVE) && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
    last_vec = &vec;
    // Whole-vector compare also flags non-one-hot results.
    mismatch = sample && (observed != expected);
  end

  // Next-state logic: start is honoured only outside DRIVE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = DRIVE;
      DRIVE:   if (sample && last_vec) state_next = DONE;
      DONE:    if (bus.start) state_next = DRIVE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state  <= state_next;
      busy_q <= (state_next == DRIVE);
      done_q <= (state_next == DONE);
    end
  end

  // Sweep datapath: vector stepping, hold counter, error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      hold_cnt   <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else if (accept) begin
      vec        <= '0;
      hold_cnt   <= '0;
      err_count  <= '0;
      first_fail <= '0;
      fail_valid <= 1'b0;
    end else if (state == DRIVE) begin
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          first_fail <= vec;
          fail_valid <= 1'b1;
        end
      end
      if (sample) begin
        hold_cnt <= '0;
        // The final vector stays on the bus after the sweep ends.
        if (!last_vec) vec <= vec + 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign bus.a_out      = a_val;
  assign bus.b_out      = b_val;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = done_q && (err_count == '0);
  assign bus.err_count  = err_count;
  assign bus.first_fail = first_fail;
  assign bus.fail_valid = fail_valid;
endmodule
